// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: pipe results, long-result
// handshake, register file write ports and status.
interface regfile_wb_arbiter_if #(
  parameter int LQ_DEPTH = 4
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic [1:0]        pipe_valid;
  logic [1:0][4:0]   pipe_addr;
  logic [1:0][31:0]  pipe_data;
  logic              lsrc_valid;
  logic              lsrc_ready;
  logic [4:0]        lsrc_addr;
  logic [31:0]       lsrc_data;
  logic [1:0]        write_ena;
  logic [1:0][4:0]   write_addr;
  logic [1:0][31:0]  write_data;
  logic [31:0]       busy_mask;
  logic [CW-1:0]     lq_count;

  modport master (
    output pipe_valid, pipe_addr, pipe_data,
    output lsrc_valid, lsrc_addr, lsrc_data,
    input  lsrc_ready,
    input  write_ena, write_addr, write_data,
    input  busy_mask, lq_count
  );

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data,
    input  lsrc_valid, lsrc_addr, lsrc_data,
    output lsrc_ready,
    output write_ena, write_addr, write_data,
    output busy_mask, lq_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Dual write-port arbiter: in-order pipe results plus
// an ordered queue of long-latency results.
module regfile_wb_arbiter #(
  parameter int LQ_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [4:0]       r_q_addr [LQ_DEPTH];
  logic [31:0]      r_q_data [LQ_DEPTH];

  logic [1:0]       r_wena;
  logic [1:0][4:0]  r_waddr;
  logic [1:0][31:0] r_wdata;

  logic [1:0]       w_p;
  logic             w_ready;
  logic             w_push;
  logic             w_has1;
  logic             w_has2;
  logic [PW-1:0]    w_head1;
  logic [1:0]       w_s_ena;
  logic [1:0][4:0]  w_s_addr;
  logic [1:0][31:0] w_s_data;
  logic [1:0]       w_pops;
  logic             w_coll;
  logic             w_s0_wins;
  logic [1:0]       w_fin;
  logic [31:0]      w_busy;

  // Writes to r0 are swallowed: they never claim a slot.
  assign w_p[0] = bus.pipe_valid[0] &
                  (bus.pipe_addr[0] != 5'd0);
  assign w_p[1] = bus.pipe_valid[1] &
                  (bus.pipe_addr[1] != 5'd0);

  assign w_ready = !rst &&
                   (r_count < CW'(LQ_DEPTH));
  assign w_push  = bus.lsrc_valid & w_ready &
                   (bus.lsrc_addr != 5'd0);
  assign w_has1  = r_count != '0;
  assign w_has2  = r_count > CW'(1);
  assign w_head1 = r_head + PW'(1);

  // Fill free slots from the queue, oldest entry into
  // the lowest free slot.
  always_comb begin
    w_s_ena  = w_p;
    w_s_addr = bus.pipe_addr;
    w_s_data = bus.pipe_data;
    w_pops   = 2'd0;
    unique case (1'b1)
      (w_p == 2'b11): begin
      end
      (w_p == 2'b01): begin
        if (w_has1) begin
          w_s_ena[1]  = 1'b1;
          w_s_addr[1] = r_q_addr[r_head];
          w_s_data[1] = r_q_data[r_head];
          w_pops      = 2'd1;
        end
      end
      (w_p == 2'b10): begin
        if (w_has1) begin
          w_s_ena[0]  = 1'b1;
          w_s_addr[0] = r_q_addr[r_head];
          w_s_data[0] = r_q_data[r_head];
          w_pops      = 2'd1;
        end
      end
      default: begin
        if (w_has1) begin
          w_s_ena[0]  = 1'b1;
          w_s_addr[0] = r_q_addr[r_head];
          w_s_data[0] = r_q_data[r_head];
          w_pops      = 2'd1;
        end
        if (w_has2) begin
          w_s_ena[1]  = 1'b1;
          w_s_addr[1] = r_q_addr[w_head1];
          w_s_data[1] = r_q_data[w_head1];
          w_pops      = 2'd2;
        end
      end
    endcase
  end

  // Slot 1 is the younger write except when slot 0 is
  // a pipe result and slot 1 came from the queue.
  assign w_coll    = w_s_ena[0] & w_s_ena[1] &
                     (w_s_addr[0] == w_s_addr[1]);
  assign w_s0_wins = w_p[0] & ~w_p[1];
  assign w_fin[0]  = w_s_ena[0] &
                     ~(w_coll & ~w_s0_wins);
  assign w_fin[1]  = w_s_ena[1] &
                     ~(w_coll & w_s0_wins);

  // Registered register-file write ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wena  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wena  <= w_fin;
      r_waddr <= w_s_addr;
      r_wdata <= w_s_data;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      r_head  <= r_head + PW'(w_pops);
      r_count <= r_count + CW'(w_push) -
                 CW'(w_pops);
    end
  end

  // Queue payload storage; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_tail] <= bus.lsrc_addr;
      r_q_data[r_tail] <= bus.lsrc_data;
    end
  end

  // Busy mask from live queue entries and pending writes.
  always_comb begin
    logic [PW-1:0] off;
    w_busy = '0;
    off    = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      off = PW'(i) - r_head;
      if ({1'b0, off} < r_count)
        w_busy[r_q_addr[i]] = 1'b1;
    end
    for (int s = 0; s < 2; s++) begin
      if (r_wena[s])
        w_busy[r_waddr[s]] = 1'b1;
    end
  end

  assign bus.lsrc_ready = w_ready;
  assign bus.write_ena  = r_wena;
  assign bus.write_addr = r_waddr;
  assign bus.write_data = r_wdata;
  assign bus.busy_mask  = w_busy;
  assign bus.lq_count   = r_count;

endmodule
